vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 193 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line/frame counters, sync and blanking decode,
// built-in test patterns, and a two-stage pixel-enable pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [1:0]        mode,
  input  logic [23:0]       ext_data,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_W    = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    MODE_EXT  = 2'd0,
    MODE_BARS = 2'd1,
    MODE_GRAD = 2'd2,
    MODE_BLUE = 2'd3
  } mode_e;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  mode_e         mode_q, mode_d, mode_eff;
  logic          frame_start_q, frame_start_d;

  logic          h_wrap, v_wrap, frame_top, active, hs_on, vs_on;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_colour, pattern;

  logic          act1_q, hs1_q, vs1_q;
  mode_e         mode1_q;
  logic [23:0]   pat1_q;

  logic          valid_q, hsync_q, vsync_q;
  logic [23:0]   rgb_q, rgb_d;

  always_comb begin
    h_wrap    = (int'(h_cnt_q) == H_TOTAL - 1);
    v_wrap    = (int'(v_cnt_q) == V_TOTAL - 1);
    frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
    active    = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    hs_on     = (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
    vs_on     = (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);
    // The first pixel of a frame already uses the mode being latched with it
    mode_eff  = frame_top ? mode_e'(mode) : mode_q;
  end

  assign h_addr = active ? ADDR_W'(h_cnt_q) : '0;
  assign v_addr = active ? ADDR_W'(v_cnt_q) : '0;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    mode_d        = mode_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (frame_top) begin
        mode_d = mode_e'(mode);
      end
      if (h_wrap) begin
        h_cnt_d = '0;
        if (v_wrap) begin
          v_cnt_d       = '0;
          frame_cnt_d   = frame_cnt_q + 8'd1;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      mode_q        <= MODE_EXT;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Bar index by threshold compare; the last bar absorbs any remainder columns
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt_q) >= k * BAR_W) begin
        bar_idx = 3'(k);
      end
    end
    case (bar_idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  end

  always_comb begin
    pattern = 24'h000000;
    case (mode_eff)
      MODE_BARS: pattern = bar_colour;
      MODE_GRAD: pattern = {8'(h_cnt_q) + frame_cnt_q, 8'(v_cnt_q),
                            8'(h_cnt_q) ^ 8'(v_cnt_q)};
      MODE_BLUE: pattern = 24'h0000FF;
      default:   pattern = 24'h000000;
    endcase
  end

  // External pixels arrive one tick after their address, so the mux sits in stage 2
  always_comb begin
    rgb_d = 24'h000000;
    if (act1_q) begin
      rgb_d = (mode1_q == MODE_EXT) ? ext_data : pat1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      mode1_q <= MODE_EXT;
      pat1_q  <= '0;
      valid_q <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      rgb_q   <= '0;
    end else if (pix_en) begin
      act1_q  <= active;
      hs1_q   <= hs_on;
      vs1_q   <= vs_on;
      mode1_q <= mode_eff;
      pat1_q  <= pattern;
      valid_q <= act1_q;
      hsync_q <= hs1_q ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs1_q ? SYNC_POL : ~SYNC_POL;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a small-geometry instance with active-high sync
// and a default-geometry instance sharing clock, reset, pix_en and mode.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam bit SPOL = 1'b1;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
  } exp_t;

  logic        clk, reset, pix_en;
  logic [1:0]  mode;
  logic [23:0] ext_data;

  logic [9:0]  h_addr, v_addr;
  logic        hsync, vsync, valid, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b, frame_cnt;

  logic [9:0]  d_h_addr, d_v_addr;
  logic        d_hsync, d_vsync, d_valid, d_frame_start;
  logic [7:0]  d_vga_r, d_vga_g, d_vga_b, d_frame_cnt;

  exp_t        sbq[$];
  exp_t        lastExp;
  int          mh, mv, mfc;
  logic [1:0]  mmode;
  logic        expFs;
  logic [23:0] memNext;
  int          checks = 0;
  int          passed = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SPOL), .ADDR_W(10)
  ) u_dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode), .ext_data(ext_data),
    .h_addr(h_addr), .v_addr(v_addr), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode), .ext_data(ext_data),
    .h_addr(d_h_addr), .v_addr(d_v_addr), .hsync(d_hsync), .vsync(d_vsync), .valid(d_valid),
    .vga_r(d_vga_r), .vga_g(d_vga_g), .vga_b(d_vga_b),
    .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] memData(input int h, input int v);
    logic [7:0] hb, vb;
    hb = h[7:0];
    vb = v[7:0];
    return {hb ^ 8'h5A, vb + 8'h11, hb + vb + 8'h03};
  endfunction

  function automatic logic [23:0] barColour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t modelOut(input int h, input int v, input logic [1:0] md, input int fc);
    exp_t e;
    logic [7:0] hb, vb, fb;
    int idx;
    hb = h[7:0];
    vb = v[7:0];
    fb = fc[7:0];
    e.hs  = (h >= HA + HF && h < HA + HF + HS) ? SPOL : ~SPOL;
    e.vs  = (v >= VA + VF && v < VA + VF + VS) ? SPOL : ~SPOL;
    e.vld = (h < HA) && (v < VA);
    e.rgb = 24'h0;
    if (e.vld) begin
      case (md)
        2'd0: e.rgb = memData(h, v);
        2'd1: begin
          idx = h / (HA / 8);
          if (idx > 7) idx = 7;
          e.rgb = barColour(idx);
        end
        2'd2: e.rgb = {hb + fb, vb, hb ^ vb};
        default: e.rgb = 24'h0000FF;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t idleExp();
    exp_t e;
    e.hs  = ~SPOL;
    e.vs  = ~SPOL;
    e.vld = 1'b0;
    e.rgb = 24'h0;
    return e;
  endfunction

  function automatic logic [19:0] addrExp();
    if (mh < HA && mv < VA) return {10'(mh), 10'(mv)};
    return 20'h0;
  endfunction

  function automatic exp_t obsVec();
    exp_t e;
    e.hs  = hsync;
    e.vs  = vsync;
    e.vld = valid;
    e.rgb = {vga_r, vga_g, vga_b};
    return e;
  endfunction

  // One clock of stimulus; on a tick the model output for the current counters is queued
  task automatic step(input logic en);
    logic [1:0] md;
    pix_en = en;
    expFs  = 1'b0;
    if (en) begin
      md = (mh == 0 && mv == 0) ? mode : mmode;
      if (mh == 0 && mv == 0) mmode = mode;
      sbq.push_back(modelOut(mh, mv, md, mfc));
      memNext = (mh < HA && mv < VA) ? memData(mh, mv) : memData(0, 0);
    end
    @(posedge clk);
    #1;
    if (en) begin
      ext_data = memNext;
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv    = 0;
          mfc   = (mfc + 1) % 256;
          expFs = 1'b1;
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
    end
  endtask

  task automatic applyReset(input logic [1:0] md);
    reset    = 1'b1;
    pix_en   = 1'b0;
    mode     = md;
    ext_data = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    mh = 0; mv = 0; mfc = 0; mmode = 2'd0; expFs = 1'b0;
    sbq.delete();
    sbq.push_back(idleExp());
    lastExp = idleExp();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b1; mode = 2'd3; ext_data = 24'hABCDEF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (obsVec() !== idleExp()) $display("[TB] FAIL reset_out: got %h expected %h", obsVec(), idleExp()); else passed++;
    checks++; if ({h_addr, v_addr} !== 20'h0) $display("[TB] FAIL reset_addr: got %h expected 0", {h_addr, v_addr}); else passed++;
    checks++; if ({frame_start, frame_cnt} !== 9'h0) $display("[TB] FAIL reset_frame: got %h expected 0", {frame_start, frame_cnt}); else passed++;
    checks++; if ({d_hsync, d_vsync, d_valid, d_vga_r, d_vga_g, d_vga_b} !== {1'b1, 1'b1, 1'b0, 24'h0})
      $display("[TB] FAIL reset_def_out: got %h expected %h", {d_hsync, d_vsync, d_valid, d_vga_r, d_vga_g, d_vga_b}, {1'b1, 1'b1, 1'b0, 24'h0});
    else passed++;
    checks++; if ({d_h_addr, d_v_addr, d_frame_start, d_frame_cnt} !== 29'h0)
      $display("[TB] FAIL reset_def_misc: got %h expected 0", {d_h_addr, d_v_addr, d_frame_start, d_frame_cnt});
    else passed++;
  endtask

  task automatic test_default_timing();
    int idx, hc;
    logic expHs, expV;
    applyReset(2'd3);
    for (int t = 1; t <= 1700; t++) begin
      pix_en = 1'b1;
      @(posedge clk);
      #1;
      idx   = (t >= 2) ? (t - 2) % 800 : 0;
      expHs = !(t >= 2 && idx >= 656 && idx < 752);
      expV  = (t >= 2) && (idx < 640);
      checks++;
      if ({d_hsync, d_vsync, d_valid, d_vga_r, d_vga_g, d_vga_b} !== {expHs, 1'b1, expV, expV ? 24'h0000FF : 24'h0})
        $display("[TB] FAIL def_timing tick %0d: got %h expected %h", t,
                 {d_hsync, d_vsync, d_valid, d_vga_r, d_vga_g, d_vga_b}, {expHs, 1'b1, expV, expV ? 24'h0000FF : 24'h0});
      else passed++;
      hc = t % 800;
      checks++;
      if ({d_h_addr, d_v_addr} !== ((hc < 640) ? {10'(hc), 10'(t / 800)} : 20'h0))
        $display("[TB] FAIL def_addr tick %0d: got %h expected %h", t, {d_h_addr, d_v_addr},
                 (hc < 640) ? {10'(hc), 10'(t / 800)} : 20'h0);
      else passed++;
    end
  endtask

  task automatic test_bars();
    exp_t e;
    applyReset(2'd1);
    for (int i = 1; i <= FR + 4; i++) begin
      checks++; if ({h_addr, v_addr} !== addrExp()) $display("[TB] FAIL bars_addr: got %h expected %h", {h_addr, v_addr}, addrExp()); else passed++;
      step(1'b1);
      e = sbq.pop_front();
      lastExp = e;
      checks++; if (obsVec() !== e) $display("[TB] FAIL bars_pixel: got %h expected %h", obsVec(), e); else passed++;
      checks++; if ({frame_start, frame_cnt} !== {expFs, mfc[7:0]}) $display("[TB] FAIL bars_frame: got %h expected %h", {frame_start, frame_cnt}, {expFs, mfc[7:0]}); else passed++;
      if (i == 4) begin
        checks++; if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 24'hFFFF00}) $display("[TB] FAIL bar1_colour: got %h expected %h", {valid, vga_r, vga_g, vga_b}, {1'b1, 24'hFFFF00}); else passed++;
      end
      if (i == 17) begin
        checks++; if ({valid, vga_r, vga_g, vga_b} !== {1'b1, 24'h000000}) $display("[TB] FAIL last_bar_colour: got %h expected %h", {valid, vga_r, vga_g, vga_b}, {1'b1, 24'h000000}); else passed++;
      end
      if (i == 20) begin
        checks++; if ({valid, vga_r, vga_g, vga_b} !== 25'h0) $display("[TB] FAIL bars_blank: got %h expected 0", {valid, vga_r, vga_g, vga_b}); else passed++;
      end
    end
  endtask

  task automatic test_ext_data();
    exp_t e;
    applyReset(2'd0);
    for (int i = 1; i <= FR + 4; i++) begin
      checks++; if ({h_addr, v_addr} !== addrExp()) $display("[TB] FAIL ext_addr: got %h expected %h", {h_addr, v_addr}, addrExp()); else passed++;
      step(1'b1);
      e = sbq.pop_front();
      lastExp = e;
      checks++; if (obsVec() !== e) $display("[TB] FAIL ext_pixel: got %h expected %h", obsVec(), e); else passed++;
    end
  endtask

  task automatic test_gradient();
    exp_t e;
    applyReset(2'd2);
    for (int i = 1; i <= 2 * FR + 4; i++) begin
      step(1'b1);
      e = sbq.pop_front();
      lastExp = e;
      checks++; if (obsVec() !== e) $display("[TB] FAIL grad_pixel: got %h expected %h", obsVec(), e); else passed++;
      checks++; if ({frame_start, frame_cnt} !== {expFs, mfc[7:0]}) $display("[TB] FAIL grad_frame: got %h expected %h", {frame_start, frame_cnt}, {expFs, mfc[7:0]}); else passed++;
    end
  endtask

  task automatic test_pix_en_toggle();
    exp_t e;
    logic en, prevHs;
    int nRise;
    int rise[2];
    applyReset(2'd2);
    nRise = 0; rise[0] = 0; rise[1] = 0;
    prevHs = hsync;
    for (int i = 0; i < 6 * HT; i++) begin
      en = (i % 2 == 0);
      checks++; if ({h_addr, v_addr} !== addrExp()) $display("[TB] FAIL toggle_addr: got %h expected %h", {h_addr, v_addr}, addrExp()); else passed++;
      step(en);
      if (en) begin
        e = sbq.pop_front();
        lastExp = e;
      end
      checks++; if (obsVec() !== lastExp) $display("[TB] FAIL toggle_pixel: got %h expected %h", obsVec(), lastExp); else passed++;
      if (hsync === SPOL && prevHs !== SPOL && nRise < 2) begin
        rise[nRise] = i;
        nRise++;
      end
      prevHs = hsync;
    end
    checks++;
    if (nRise < 2 || rise[1] - rise[0] != 2 * HT)
      $display("[TB] FAIL toggle_line_period: got %0d edges, period %0d expected period %0d", nRise, rise[1] - rise[0], 2 * HT);
    else passed++;
  endtask

  task automatic test_mode_switch();
    exp_t e;
    int nFs;
    applyReset(2'd1);
    nFs = 0;
    for (int i = 1; i <= 2 * FR; i++) begin
      if (mv == 3 && mh == 0) mode = 2'd3;
      step(1'b1);
      e = sbq.pop_front();
      lastExp = e;
      checks++; if (obsVec() !== e) $display("[TB] FAIL switch_pixel: got %h expected %h", obsVec(), e); else passed++;
      if (frame_start === 1'b1) nFs++;
      if (i == 3 * HT + 7) begin
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h00FFFF) $display("[TB] FAIL switch_bars_persist: got %h expected 00ffff", {vga_r, vga_g, vga_b}); else passed++;
      end
      if (i == FR + 2) begin
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h0000FF) $display("[TB] FAIL switch_blue: got %h expected 0000ff", {vga_r, vga_g, vga_b}); else passed++;
      end
    end
    checks++; if (nFs != 2) $display("[TB] FAIL switch_frame_start_count: got %0d expected 2", nFs); else passed++;
  endtask

  task automatic test_async_reset();
    applyReset(2'd2);
    repeat (HT + 7) step(1'b1);
    checks++; if (valid !== 1'b1) $display("[TB] FAIL pre_reset_valid: got %b expected 1", valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (obsVec() !== idleExp()) $display("[TB] FAIL async_out: got %h expected %h", obsVec(), idleExp()); else passed++;
    checks++; if ({h_addr, v_addr, frame_start, frame_cnt} !== 29'h0) $display("[TB] FAIL async_misc: got %h expected 0", {h_addr, v_addr, frame_start, frame_cnt}); else passed++;
    checks++; if ({d_hsync, d_vsync, d_valid, d_vga_r, d_vga_g, d_vga_b} !== {1'b1, 1'b1, 1'b0, 24'h0})
      $display("[TB] FAIL async_def_out: got %h expected %h", {d_hsync, d_vsync, d_valid, d_vga_r, d_vga_g, d_vga_b}, {1'b1, 1'b1, 1'b0, 24'h0});
    else passed++;
  endtask

  task automatic test_frame_wrap();
    exp_t e;
    applyReset(2'd2);
    for (int i = 1; i <= 256 * FR; i++) begin
      step(1'b1);
      e = sbq.pop_front();
      lastExp = e;
      checks++; if (obsVec() !== e) $display("[TB] FAIL wrap_pixel: got %h expected %h", obsVec(), e); else passed++;
      checks++; if ({frame_start, frame_cnt} !== {expFs, mfc[7:0]}) $display("[TB] FAIL wrap_frame: got %h expected %h", {frame_start, frame_cnt}, {expFs, mfc[7:0]}); else passed++;
      if (i == 255 * FR) begin
        checks++; if (frame_cnt !== 8'd255) $display("[TB] FAIL frame_cnt_255: got %0d expected 255", frame_cnt); else passed++;
      end
      if (i == 256 * FR) begin
        checks++; if ({frame_start, frame_cnt} !== {1'b1, 8'd0}) $display("[TB] FAIL frame_cnt_wrap: got %h expected 100", {frame_start, frame_cnt}); else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; mode = 2'd0; ext_data = 24'h0;
    test_reset();
    test_default_timing();
    test_bars();
    test_ext_data();
    test_gradient();
    test_pix_en_toggle();
    test_mode_switch();
    test_async_reset();
    test_frame_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
